fifo_in_buffer: RTL and testbench



---
 rtl/fifo_in_buffer_pkg.sv | 31 +++
 rtl/fifo_in_buffer_if.sv | 40 ++++
 rtl/fifo_in_buffer_credit_return_counter.sv | 40 ++++
 rtl/fifo_in_buffer.sv | 109 ++++++++++
 tb/tb_fifo_in_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_in_buffer_pkg.sv
// ============================================================================
// Module   : fifo_in_buffer_pkg
// Purpose  : Flit link widths, flit type codes and flit helpers for the NIC
//            receive buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_in_buffer_pkg;

  // Same values as the NIC-defines.v link widths and codes.
  localparam int FLIT_WIDTH        = 16;
  localparam int MAX_PACKET_LENGHT = 4;
  localparam int FLIT_TYPE_BITS    = 2;

  typedef logic [FLIT_WIDTH-1:0]     flit_t;
  typedef logic [FLIT_TYPE_BITS-1:0] flit_type_t;

  localparam flit_type_t FLIT_BODY      = 2'b00;
  localparam flit_type_t FLIT_TAIL      = 2'b01;
  localparam flit_type_t FLIT_HEAD      = 2'b10;
  localparam flit_type_t FLIT_HEAD_TAIL = 2'b11;

  // The type field occupies the top bits of every flit.
  function automatic flit_type_t get_flit_type(input flit_t f);
    return f[FLIT_WIDTH-1 -: FLIT_TYPE_BITS];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_in_buffer_if.sv
// ============================================================================
// Module   : fifo_in_buffer_if
// Purpose  : Link-side flit input and core-side packet handshake of the
//            receive buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_in_buffer_if
  import fifo_in_buffer_pkg::*;
#(
  parameter int N_BITS_VNET_ID       = 2,
  parameter int N_BITS_PACKET_LENGHT = 4
);
  logic [FLIT_WIDTH-1:0]                   flit_i;
  logic                                    is_valid_i;
  logic [N_BITS_VNET_ID-1:0]               vnet_id_i;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_o;
  logic [N_BITS_PACKET_LENGHT-1:0]         pkt_length_o;
  logic [N_BITS_VNET_ID-1:0]               vnet_id_o;
  logic                                    pkt_valid_o;
  logic                                    pkt_ack_i;
  logic                                    credit_out_o;
  logic                                    err_o;
  logic                                    free_slot_o;

  modport master (
    output flit_i, is_valid_i, vnet_id_i, pkt_ack_i,
    input  pkt_o, pkt_length_o, vnet_id_o, pkt_valid_o,
           credit_out_o, err_o, free_slot_o
  );

  modport slave (
    input  flit_i, is_valid_i, vnet_id_i, pkt_ack_i,
    output pkt_o, pkt_length_o, vnet_id_o, pkt_valid_o,
           credit_out_o, err_o, free_slot_o
  );
endinterface

`default_nettype wire

// File: rtl/fifo_in_buffer_credit_return_counter.sv
// ============================================================================
// Module   : fifo_in_buffer_credit_return_counter
// Purpose  : Holds credits owed upstream and releases one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_in_buffer_credit_return_counter #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_load_val,
  output logic              o_credit
);
  // One extra bit: a new load can land on top of a partly drained count.
  logic [W:0] r_pending;
  logic [W:0] w_drained;

  always_comb begin
    w_drained = r_pending;
    if (r_pending != '0) w_drained = r_pending - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else if (i_load) begin
      r_pending <= w_drained + {1'b0, i_load_val};
    end else begin
      r_pending <= w_drained;
    end
  end

  assign o_credit = (r_pending != '0);

endmodule

`default_nettype wire

// File: rtl/fifo_in_buffer.sv
// ============================================================================
// Module   : fifo_in_buffer
// Purpose  : Per-VC receive buffer: reassembles flits into a packet, hands it
//            to the core on valid/ack and returns one credit per freed flit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_in_buffer
  import fifo_in_buffer_pkg::*;
#(
  parameter int N_BITS_VNET_ID       = 2,
  parameter int N_BITS_PACKET_LENGHT = 4
) (
  input wire logic        clk,
  input wire logic        rst,
  fifo_in_buffer_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECEIVE = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;

  localparam logic [N_BITS_PACKET_LENGHT-1:0] c_max_len =
    N_BITS_PACKET_LENGHT'(MAX_PACKET_LENGHT);

  logic [1:0]                      r_state;
  logic [N_BITS_PACKET_LENGHT-1:0] r_count;
  logic [N_BITS_VNET_ID-1:0]       r_vnet;
  logic                            r_err;
  flit_t                           r_buf [MAX_PACKET_LENGHT];

  flit_type_t w_type;
  logic       w_accept;
  logic       w_drop;
  logic       w_ack;

  assign w_type = get_flit_type(bus.flit_i);
  assign w_ack  = (r_state == S_READY) && bus.pkt_ack_i;

  always_comb begin
    w_accept = 1'b0;
    w_drop   = 1'b0;
    if (bus.is_valid_i) begin
      case (r_state)
        S_IDLE: begin
          w_accept = (w_type == FLIT_HEAD) || (w_type == FLIT_HEAD_TAIL);
          w_drop   = !w_accept;
        end
        S_RECEIVE: begin
          w_accept = (r_count != c_max_len) &&
                     ((w_type == FLIT_BODY) || (w_type == FLIT_TAIL));
          w_drop   = !w_accept;
        end
        default: w_drop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_vnet  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < MAX_PACKET_LENGHT; i++) r_buf[i] <= '0;
    end else begin
      r_err <= w_drop;
      if (w_ack) begin
        r_state <= S_IDLE;
        r_count <= '0;
        for (int i = 0; i < MAX_PACKET_LENGHT; i++) r_buf[i] <= '0;
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
        for (int i = 0; i < MAX_PACKET_LENGHT; i++) begin
          if (r_count == N_BITS_PACKET_LENGHT'(i)) r_buf[i] <= bus.flit_i;
        end
        if (r_state == S_IDLE) begin
          r_vnet  <= bus.vnet_id_i;
          r_state <= (w_type == FLIT_HEAD) ? S_RECEIVE : S_READY;
        end else if (w_type == FLIT_TAIL) begin
          r_state <= S_READY;
        end
      end
    end
  end

  fifo_in_buffer_credit_return_counter #(
    .W (N_BITS_PACKET_LENGHT)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ack),
    .i_load_val (r_count),
    .o_credit   (bus.credit_out_o)
  );

  for (genvar k = 0; k < MAX_PACKET_LENGHT; k++) begin : g_pack
    assign bus.pkt_o[k*FLIT_WIDTH +: FLIT_WIDTH] = r_buf[k];
  end

  assign bus.pkt_length_o = r_count;
  assign bus.vnet_id_o    = r_vnet;
  assign bus.pkt_valid_o  = (r_state == S_READY);
  assign bus.err_o        = r_err;
  assign bus.free_slot_o  = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_in_buffer.sv
// ============================================================================
// Module   : tb_fifo_in_buffer
// Purpose  : Directed self-checking bench for the NIC receive buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_in_buffer;
  import fifo_in_buffer_pkg::*;

  localparam int PW = MAX_PACKET_LENGHT * FLIT_WIDTH;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   credit_total;
  int   credit_run;
  int   last_run;

  typedef struct {
    logic [PW-1:0] pkt;
    logic [3:0]    len;
    logic [1:0]    vnet;
  } exp_t;
  exp_t sb[$];

  fifo_in_buffer_if #(.N_BITS_VNET_ID(2), .N_BITS_PACKET_LENGHT(4)) bus ();

  fifo_in_buffer #(
    .N_BITS_VNET_ID       (2),
    .N_BITS_PACKET_LENGHT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Credit pulses observed mid-cycle; a run closes when the line drops.
  always @(negedge clk) begin
    if (bus.credit_out_o === 1'b1) begin
      credit_total <= credit_total + 1;
      credit_run   <= credit_run + 1;
    end else if (credit_run != 0) begin
      last_run   <= credit_run;
      credit_run <= 0;
    end
  end

  function automatic flit_t mk(input flit_type_t t, input logic [13:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input flit_t f, input logic [1:0] v);
    bus.flit_i     = f;
    bus.vnet_id_i  = v;
    bus.is_valid_i = 1'b1;
    tick();
    bus.is_valid_i = 1'b0;
    bus.flit_i     = '0;
    bus.vnet_id_i  = '0;
  endtask

  task automatic ack();
    bus.pkt_ack_i = 1'b1;
    tick();
    bus.pkt_ack_i = 1'b0;
  endtask

  task automatic check_pkt(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, PW'(bus.pkt_valid_o), PW'(1));
      chk({tag, "_pkt"},   bus.pkt_o, e.pkt);
      chk({tag, "_len"},   PW'(bus.pkt_length_o), PW'(e.len));
      chk({tag, "_vnet"},  PW'(bus.vnet_id_o), PW'(e.vnet));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, PW'(bus.pkt_valid_o), PW'(0));
    chk({tag, "_credit"}, PW'(bus.credit_out_o), PW'(0));
    chk({tag, "_err"}, PW'(bus.err_o), PW'(0));
    chk({tag, "_free"}, PW'(bus.free_slot_o), PW'(1));
    chk({tag, "_len"}, PW'(bus.pkt_length_o), PW'(0));
    chk({tag, "_vnet"}, PW'(bus.vnet_id_o), PW'(0));
    chk({tag, "_pkt"}, bus.pkt_o, PW'(0));
  endtask

  initial begin
    flit_t f0, f1, f2, f3;
    int    base;
    checks = 0; errors = 0;
    credit_total = 0; credit_run = 0; last_run = 0;
    rst = 1'b0;
    bus.flit_i = '0; bus.is_valid_i = 1'b0; bus.vnet_id_i = '0; bus.pkt_ack_i = 1'b0;
    repeat (2) tick();
    check_reset("reset");
    rst = 1'b1;
    tick();

    // HEAD/BODY/TAIL, vnet sampled only with the head
    f0 = mk(FLIT_HEAD, 14'h011); f1 = mk(FLIT_BODY, 14'h022); f2 = mk(FLIT_TAIL, 14'h033);
    sb.push_back('{pkt: {16'h0, f2, f1, f0}, len: 4'd3, vnet: 2'd2});
    send(f0, 2'd2); send(f1, 2'd0); send(f2, 2'd1);
    check_pkt("p3");
    chk("p3_busy", PW'(bus.free_slot_o), PW'(0));
    send(mk(FLIT_BODY, 14'h03F), 2'd0);
    chk("ready_drop_err", PW'(bus.err_o), PW'(1));
    chk("ready_drop_len", PW'(bus.pkt_length_o), PW'(3));
    ack();
    chk("p3_ack_valid", PW'(bus.pkt_valid_o), PW'(0));
    chk("p3_ack_free", PW'(bus.free_slot_o), PW'(1));
    repeat (6) tick();
    chk("p3_credit_run", PW'(last_run), PW'(3));
    chk("p3_credit_total", PW'(credit_total), PW'(3));

    // Single HEAD_TAIL
    f0 = mk(FLIT_HEAD_TAIL, 14'h044);
    sb.push_back('{pkt: {48'h0, f0}, len: 4'd1, vnet: 2'd1});
    send(f0, 2'd1);
    check_pkt("p1");
    ack();
    repeat (4) tick();
    chk("p1_credit_run", PW'(last_run), PW'(1));
    chk("p1_credit_total", PW'(credit_total), PW'(4));

    // BODY while idle is dropped and earns no credit
    send(mk(FLIT_BODY, 14'h055), 2'd0);
    chk("idle_body_err", PW'(bus.err_o), PW'(1));
    chk("idle_body_free", PW'(bus.free_slot_o), PW'(1));
    chk("idle_body_valid", PW'(bus.pkt_valid_o), PW'(0));
    tick();
    chk("idle_body_err_end", PW'(bus.err_o), PW'(0));
    repeat (4) tick();
    chk("idle_body_no_credit", PW'(credit_total), PW'(4));

    // Ack of B lands while A's credits are still draining
    f0 = mk(FLIT_HEAD, 14'h051); f1 = mk(FLIT_BODY, 14'h052); f2 = mk(FLIT_TAIL, 14'h053);
    sb.push_back('{pkt: {16'h0, f2, f1, f0}, len: 4'd3, vnet: 2'd3});
    send(f0, 2'd3); send(f1, 2'd3); send(f2, 2'd3);
    check_pkt("pa");
    ack();
    chk("pa_first_credit", PW'(bus.credit_out_o), PW'(1));
    f3 = mk(FLIT_HEAD_TAIL, 14'h060);
    sb.push_back('{pkt: {48'h0, f3}, len: 4'd1, vnet: 2'd0});
    send(f3, 2'd0);
    check_pkt("pb");
    ack();
    repeat (6) tick();
    chk("overlap_credit_run", PW'(last_run), PW'(4));
    chk("overlap_credit_total", PW'(credit_total), PW'(8));

    // Overflow: fifth flit and a following TAIL both dropped
    send(mk(FLIT_HEAD, 14'h071), 2'd1);
    for (int i = 0; i < 3; i++) send(mk(FLIT_BODY, 14'(14'h072 + i)), 2'd1);
    chk("full_valid", PW'(bus.pkt_valid_o), PW'(0));
    send(mk(FLIT_BODY, 14'h075), 2'd1);
    chk("ovf_err", PW'(bus.err_o), PW'(1));
    chk("ovf_valid", PW'(bus.pkt_valid_o), PW'(0));
    chk("ovf_free", PW'(bus.free_slot_o), PW'(0));
    send(mk(FLIT_TAIL, 14'h076), 2'd1);
    chk("ovf_tail_err", PW'(bus.err_o), PW'(1));
    chk("ovf_tail_valid", PW'(bus.pkt_valid_o), PW'(0));
    rst = 1'b0;
    #1;
    check_reset("rst_full");
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-packet at count 2 takes effect without a clock edge
    send(mk(FLIT_HEAD, 14'h081), 2'd3);
    send(mk(FLIT_BODY, 14'h082), 2'd3);
    chk("mid_len", PW'(bus.pkt_length_o), PW'(2));
    #2;
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    tick();
    rst = 1'b1;
    tick();
    base = credit_total;
    f0 = mk(FLIT_HEAD_TAIL, 14'h07A);
    sb.push_back('{pkt: {48'h0, f0}, len: 4'd1, vnet: 2'd2});
    send(f0, 2'd2);
    check_pkt("post_rst");
    ack();
    repeat (4) tick();
    chk("post_rst_credit", PW'(credit_total - base), PW'(1));
    chk("sb_drained", PW'(sb.size()), PW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
